// File: rtl/fwnoc_router_egress_arb.sv
// Packet-level round-robin egress arbiter for one router output port.
// Five requesters (h,n,s,e,w) compete; a winner owns the port for a whole packet.
module fwnoc_router_egress_arb #(
    parameter int LEN_WIDTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        h_valid,
    input  logic        n_valid,
    input  logic        s_valid,
    input  logic        e_valid,
    input  logic        w_valid,
    input  logic [31:0] h_dat,
    input  logic [31:0] n_dat,
    input  logic [31:0] s_dat,
    input  logic [31:0] e_dat,
    input  logic [31:0] w_dat,
    output logic        h_ready,
    output logic        n_ready,
    output logic        s_ready,
    output logic        e_ready,
    output logic        w_ready,
    output logic        o_valid,
    output logic [31:0] o_dat,
    input  logic        o_ready,
    output logic [4:0]  grant,
    output logic        busy
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BODY = 1'b1;

    logic [0:0]           state;
    logic [2:0]           ptr;
    logic [2:0]           own;
    logic [LEN_WIDTH-1:0] cnt;

    logic [4:0]  req_valid;
    logic [31:0] req_dat [5];
    logic [2:0]  winner;
    logic [2:0]  idx;
    logic        has_req;
    logic [2:0]  sel;
    logic        active;
    logic        ld;
    logic [4:0]  ready_vec;
    logic        hs;
    logic [31:0] sel_dat;

    assign req_valid  = {w_valid, e_valid, s_valid, n_valid, h_valid};
    assign req_dat[0] = h_dat;
    assign req_dat[1] = n_dat;
    assign req_dat[2] = s_dat;
    assign req_dat[3] = e_dat;
    assign req_dat[4] = w_dat;

    function automatic logic [2:0] next_idx(input logic [2:0] i);
        return (i == 3'd4) ? 3'd0 : i + 3'd1;
    endfunction

    // First valid requester at or after ptr, wrapping 4 -> 0.
    always_comb begin
        // NOTE: every variable assigned here gets a default first so no latch is inferred.
        winner  = ptr;
        has_req = 1'b0;
        idx     = ptr;
        for (int k = 0; k < 5; k++) begin
            if (!has_req && req_valid[idx]) begin
                winner  = idx;
                has_req = 1'b1;
            end
            idx = next_idx(idx);
        end
    end

    always_comb begin
        sel       = (state == BODY) ? own : winner;
        active    = (state == BODY) || has_req;
        ld        = !o_valid || o_ready;
        grant     = '0;
        ready_vec = '0;
        if (active) begin
            grant[sel] = 1'b1;
            // A stalled owner still sees ready; the grant is never released mid-packet.
            ready_vec[sel] = ld && reset;
        end
        hs      = |(ready_vec & req_valid);
        sel_dat = req_dat[sel];
    end

    assign {w_ready, e_ready, s_ready, n_ready, h_ready} = ready_vec;
    assign busy = (state == BODY);

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!reset) begin
            state   <= IDLE;
            ptr     <= 3'd0;
            own     <= 3'd0;
            cnt     <= '0;
            o_valid <= 1'b0;
            o_dat   <= '0;
        end else begin
            if (ld) begin
                o_valid <= hs;
                if (hs) o_dat <= sel_dat;
            end
            if (hs) begin
                if (state == IDLE) begin
                    cnt <= sel_dat[LEN_WIDTH-1:0];
                    if (sel_dat[LEN_WIDTH-1:0] == '0) begin
                        ptr <= next_idx(sel);
                    end else begin
                        own   <= sel;
                        state <= BODY;
                    end
                end else begin
                    // cnt is at least 1 in BODY, so the decrement cannot wrap.
                    cnt <= cnt - LEN_WIDTH'(1);
                    if (cnt == LEN_WIDTH'(1)) begin
                        ptr   <= next_idx(own);
                        state <= IDLE;
                    end
                end
            end
        end
    end

endmodule
